// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial LSB-first subtractor with IDLE/RUN/DONE control
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] last_cnt = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] ra, rb, rd;
  logic [CW-1:0] cnt;
  logic brw, d, bout;
  // one-bit full-subtractor cell fed by the operand LSBs and the registered borrow
  assign d    = ra[0] ^ rb[0] ^ brw;
  assign bout = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & brw);
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  // next-state: accept start only in IDLE, leave RUN on the last bit, DONE lasts one cycle
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = start ? RUN : IDLE;
      RUN:     state_nx = (cnt == last_cnt) ? DONE : RUN;
      default: state_nx = IDLE;
    endcase
  end
  // operand capture and per-bit shift; result and borrow hold outside RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra  <= '0;
      rb  <= '0;
      rd  <= '0;
      brw <= 1'b0;
      cnt <= '0;
    end else if (state == IDLE && start) begin
      ra  <= a;
      rb  <= b;
      brw <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      ra  <= ra >> 1;
      rb  <= rb >> 1;
      rd  <= {d, rd[WIDTH-1:1]};
      brw <= bout;
      cnt <= cnt + 1'b1;
    end
  end
  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign diff   = rd;
  assign borrow = brw;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl: directed self-checking bench for serial_subtractor_ctrl
module tb_serial_subtractor_ctrl;
  logic clk, rst_n, start, busy, done, borrow;
  logic [7:0] a, b, diff;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  serial_subtractor_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                       output int nbusy, output bit got);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~av; b = ~bv;
    nbusy = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) got = 1;
      else begin
        if (busy) nbusy++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
    @(negedge clk);
    checks++;
    if ({busy, done, diff, borrow} !== 11'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b diff=%h borrow=%b, want all 0", busy, done, diff, borrow);
    end
    rst_n = 1'b1; start = 1'b1; a = 8'd5; b = 8'd3;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_start: busy=%b, want 1", busy);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_basic(input logic [7:0] av, input logic [7:0] bv,
                            input logic [7:0] ed, input logic eb);
    int nb;
    bit got;
    do_op(av, bv, nb, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL basic_timeout a=%h b=%h: no done within bound", av, bv);
    end
    checks++;
    if (nb != 8) begin
      errors++;
      $display("FAIL basic_busy_cycles a=%h b=%h: got %0d, want 8", av, bv, nb);
    end
    checks++;
    if (diff !== ed || borrow !== eb) begin
      errors++;
      $display("FAIL basic_result a=%h b=%h: diff=%h borrow=%b, want diff=%h borrow=%b", av, bv, diff, borrow, ed, eb);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || diff !== ed || borrow !== eb) begin
      errors++;
      $display("FAIL basic_hold a=%h b=%h: done=%b diff=%h borrow=%b, want done=0 diff=%h borrow=%b", av, bv, done, diff, borrow, ed, eb);
    end
  endtask

  task automatic test_ignore_start;
    int ndone = 0;
    @(negedge clk);
    a = 8'd9; b = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'd1; b = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (done) begin
        ndone++;
        checks++;
        if (diff !== 8'd5 || borrow !== 1'b0) begin
          errors++;
          $display("FAIL ignore_result: diff=%h borrow=%b, want diff=05 borrow=0", diff, borrow);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL ignore_done_count: got %0d, want 1", ndone);
    end
  endtask

  task automatic test_reset_mid_run;
    int ndone = 0;
    int nb;
    bit got;
    @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || diff !== 8'hE0) begin
      errors++;
      $display("FAIL midrun_pre: busy=%b diff=%h, want busy=1 diff=e0", busy, diff);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, diff, borrow} !== 11'h0) begin
      errors++;
      $display("FAIL midrun_async_clear: busy=%b done=%b diff=%h borrow=%b, want all 0", busy, done, diff, borrow);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL midrun_no_done: got %0d done pulses, want 0", ndone);
    end
    do_op(8'd7, 8'd7, nb, got);
    checks++;
    if (!got || nb != 8 || diff !== 8'h00 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL midrun_after: got=%0d busy_cycles=%0d diff=%h borrow=%b, want 1/8/00/0", got, nb, diff, borrow);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bv, ed;
    int prev = -1;
    bit got;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 16; j++) begin
        bv = 8'(j * 17);
        a = 8'(i); b = bv;
        ed = 8'(i) - bv;
        got = 0;
        for (int k = 0; k < 14 && !got; k++) begin
          @(negedge clk);
          if (done) got = 1;
        end
        checks++;
        if (!got) begin
          errors++;
          $display("FAIL b2b_timeout a=%h b=%h", 8'(i), bv);
        end else if (diff !== ed || borrow !== (8'(i) < bv)) begin
          errors++;
          $display("FAIL b2b_result a=%h b=%h: diff=%h borrow=%b, want diff=%h borrow=%b", 8'(i), bv, diff, borrow, ed, 8'(i) < bv);
        end
        if (got && prev >= 0) begin
          checks++;
          if (cyc - prev != 10) begin
            errors++;
            $display("FAIL b2b_spacing a=%h b=%h: got %0d cycles, want 10", 8'(i), bv, cyc - prev);
          end
        end
        if (got) prev = cyc;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic(8'd5, 8'd3, 8'h02, 1'b0);
    test_basic(8'd3, 8'd5, 8'hFE, 1'b1);
    test_basic(8'd0, 8'd0, 8'h00, 1'b0);
    test_basic(8'h00, 8'h01, 8'hFF, 1'b1);
    test_basic(8'hFF, 8'h00, 8'hFF, 1'b0);
    test_ignore_start;
    test_reset_mid_run;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
